dds_sweep_ctrl: RTL and testbench



---
 rtl/dds_sweep_pkg.sv | 25 ++
 rtl/dds_sweep_step.sv | 46 ++++
 rtl/dds_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the sweep-mode codes, the controller state encoding and the default
// widths of the frequency words and the dwell counter.
package dds_sweep_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int DWELL_W_DEF = 24;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_PING   = 2'd2;

    // STEP is folded into the terminal dwell cycle of RUN, so the controller
    // only ever sits in IDLE or RUN. The code is kept so the encoding stays
    // stable for anything that decodes the state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

endpackage

// File: rtl/dds_sweep_step.sv
// Saturating frequency step: next = cur +/- step, clamped at stop.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   cur    current frequency word
//   step   unsigned step magnitude
//   stop   endpoint to saturate at
//   dir    1 = sweeping up, 0 = sweeping down
//   next   next frequency word (saturated)
//   at_end next equals the endpoint
module dds_sweep_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] stop,
    input  logic         dir,
    output logic [W-1:0] next,
    output logic         at_end
);

    // One extra bit catches carry-out (up) and borrow (down), both of which
    // mean the step overshot the endpoint.
    logic [W:0] sum;
    logic [W:0] dif;

    assign sum = {1'b0, cur} + {1'b0, step};
    assign dif = {1'b0, cur} - {1'b0, step};

    always_comb begin
        next = stop;
        if (dir) begin
            if (!sum[W] && (sum[W-1:0] < stop)) begin
                next = sum[W-1:0];
            end
        end else begin
            if (!dif[W] && (dif[W-1:0] > stop)) begin
                next = dif[W-1:0];
            end
        end
    end

    assign at_end = (next == stop);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving the DDS phase-increment input.
// Latency: inc_phi shows f_start the cycle after start; each point holds dwell+1 cycles.
// Backpressure: none; start is ignored while sweeping, abort wins over everything but reset.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, abort          sweep request (IDLE only) / sweep termination
//   mode                  0 single, 1 sawtooth, 2 ping-pong, 3 single
//   f_start, f_stop       sweep endpoints, f_step step magnitude
//   dwell                 each point held dwell+1 cycles
//   inc_phi               frequency word to the DDS core
//   sweeping, done, wrap  active flag, end-of-single pulse, restart/reversal pulse
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] f_start,
    input  logic [PHASE_W-1:0] f_stop,
    input  logic [PHASE_W-1:0] f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [PHASE_W-1:0] inc_phi,
    output logic               sweeping,
    output logic               done,
    output logic               wrap
);

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    // Working endpoints: ping-pong swaps them at each reversal.
    logic [PHASE_W-1:0] lo_q, lo_d;
    logic [PHASE_W-1:0] hi_q, hi_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    // Set while the point on inc_phi is the endpoint hi_q.
    logic               last_q, last_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic               swp_q, swp_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    logic [PHASE_W-1:0] nxt;
    logic               nxt_end;

    dds_sweep_step #(.W(PHASE_W)) u_step (
        .cur    (inc_q),
        .step   (step_q),
        .stop   (hi_q),
        .dir    (dir_q),
        .next   (nxt),
        .at_end (nxt_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_SINGLE;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            last_q  <= 1'b0;
            inc_q   <= '0;
            swp_q   <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            inc_q   <= inc_d;
            swp_q   <= swp_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        last_d  = last_q;
        inc_d   = inc_q;
        swp_d   = swp_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    mode_d  = mode;
                    lo_d    = f_start;
                    hi_d    = f_stop;
                    step_d  = f_step;
                    dwell_d = dwell;
                    dir_d   = (f_stop >= f_start);
                    last_d  = (f_start == f_stop);
                    inc_d   = f_start;
                    cnt_d   = '0;
                    swp_d   = 1'b1;
                end
            end

            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    swp_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != dwell_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (!last_q || mode_q == MODE_PING) begin
                        inc_d  = nxt;
                        last_d = nxt_end;
                        wrap_d = last_q;
                        // Ping-pong reverses on arrival at an endpoint, so the
                        // step unit already aims at the far end while the
                        // endpoint dwells and the endpoint is never repeated.
                        if (nxt_end && mode_q == MODE_PING) begin
                            lo_d  = hi_q;
                            hi_d  = lo_q;
                            dir_d = ~dir_q;
                        end
                    end else if (mode_q == MODE_SAW) begin
                        inc_d  = lo_q;
                        last_d = (lo_q == hi_q);
                        wrap_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        swp_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                swp_d   = 1'b0;
            end
        endcase
    end

    assign inc_phi  = inc_q;
    assign sweeping = swp_q;
    assign done     = done_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with hand-computed expected sequences.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [23:0] dwell = '0;
    logic [31:0] inc_phi;
    logic        sweeping;
    logic        done;
    logic        wrap;

    int total = 0;
    int bad = 0;

    dds_sweep_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .f_start  (f_start),
        .f_stop   (f_stop),
        .f_step   (f_step),
        .dwell    (dwell),
        .inc_phi  (inc_phi),
        .sweeping (sweeping),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] s, input logic [23:0] d);
        mode    = m;
        f_start = a;
        f_stop  = b;
        f_step  = s;
        dwell   = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    logic [31:0] up_seq [8];
    logic [31:0] saw_seq [7];
    logic        saw_wrp [7];
    logic [31:0] png_seq [8];
    logic        png_wrp [8];

    initial begin
        up_seq  = '{100, 100, 110, 110, 120, 120, 130, 130};
        saw_seq = '{10, 20, 30, 10, 20, 30, 10};
        saw_wrp = '{0, 0, 0, 1, 0, 0, 1};
        png_seq = '{10, 20, 30, 20, 10, 20, 30, 20};
        png_wrp = '{0, 0, 0, 1, 0, 1, 0, 1};

        // Reset state
        tick();
        tick();
        chk("rst_inc", inc_phi, 32'd0);
        chk("rst_swp", {31'd0, sweeping}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        reset = 1'b0;
        tick();

        // Single up sweep, dwell 1
        go(2'd0, 100, 130, 10, 1);
        for (int i = 0; i < 8; i++) begin
            chk("up_inc", inc_phi, up_seq[i]);
            chk("up_swp", {31'd0, sweeping}, 32'd1);
            chk("up_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("up_end_done", {31'd0, done}, 32'd1);
        chk("up_end_swp", {31'd0, sweeping}, 32'd0);
        chk("up_end_inc", inc_phi, 32'd130);
        tick();
        chk("up_done_pulse", {31'd0, done}, 32'd0);
        chk("up_hold_inc", inc_phi, 32'd130);

        // Carry-out saturation
        go(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0);
        chk("ovf_p0", inc_phi, 32'hFFFF_FFF0);
        tick();
        chk("ovf_p1", inc_phi, 32'hFFFF_FFFF);
        chk("ovf_p1_done", {31'd0, done}, 32'd0);
        tick();
        chk("ovf_done", {31'd0, done}, 32'd1);
        chk("ovf_inc", inc_phi, 32'hFFFF_FFFF);

        // Single down sweep
        tick();
        go(2'd0, 50, 20, 15, 0);
        chk("dn_p0", inc_phi, 32'd50);
        tick();
        chk("dn_p1", inc_phi, 32'd35);
        tick();
        chk("dn_p2", inc_phi, 32'd20);
        tick();
        chk("dn_done", {31'd0, done}, 32'd1);
        chk("dn_inc", inc_phi, 32'd20);

        // Sawtooth repeat, then abort
        tick();
        go(2'd1, 10, 30, 10, 0);
        for (int i = 0; i < 7; i++) begin
            chk("saw_inc", inc_phi, saw_seq[i]);
            chk("saw_wrap", {31'd0, wrap}, {31'd0, saw_wrp[i]});
            chk("saw_swp", {31'd0, sweeping}, 32'd1);
            if (i < 6) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("saw_abort_swp", {31'd0, sweeping}, 32'd0);
        chk("saw_abort_inc", inc_phi, 32'd10);
        chk("saw_abort_done", {31'd0, done}, 32'd0);

        // Ping-pong
        tick();
        go(2'd2, 10, 30, 10, 0);
        for (int i = 0; i < 8; i++) begin
            chk("png_inc", inc_phi, png_seq[i]);
            chk("png_wrap", {31'd0, wrap}, {31'd0, png_wrp[i]});
            chk("png_done", {31'd0, done}, 32'd0);
            if (i < 7) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("png_abort_swp", {31'd0, sweeping}, 32'd0);
        chk("png_abort_wrap", {31'd0, wrap}, 32'd0);

        // Abort on the second point of the first sweep
        tick();
        go(2'd0, 100, 130, 10, 1);
        tick();
        tick();
        chk("ab_pre_inc", inc_phi, 32'd110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_swp", {31'd0, sweeping}, 32'd0);
        chk("ab_inc", inc_phi, 32'd110);
        chk("ab_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ab_idle_done", {31'd0, done}, 32'd0);
        end
        chk("ab_frozen", inc_phi, 32'd110);

        // start together with abort in IDLE
        abort = 1'b1;
        go(2'd0, 500, 600, 1, 0);
        abort = 1'b0;
        chk("sa_swp", {31'd0, sweeping}, 32'd0);
        chk("sa_inc", inc_phi, 32'd110);

        // start while sweeping is ignored
        tick();
        go(2'd0, 100, 130, 10, 1);
        tick();
        mode    = 2'd1;
        f_start = 999;
        f_step  = 1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("sw_p1", inc_phi, 32'd110);
        tick();
        chk("sw_p1b", inc_phi, 32'd110);
        tick();
        chk("sw_p2", inc_phi, 32'd120);
        chk("sw_swp", {31'd0, sweeping}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Zero step holds f_start indefinitely
        tick();
        go(2'd0, 40, 80, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk("z_inc", inc_phi, 32'd40);
            chk("z_swp", {31'd0, sweeping}, 32'd1);
            tick();
        end

        // Reset mid-sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_inc", inc_phi, 32'd0);
        chk("mr_swp", {31'd0, sweeping}, 32'd0);

        // Single point in sawtooth: wrap every dwell+1 cycles
        tick();
        go(2'd1, 7, 7, 3, 1);
        for (int i = 0; i < 5; i++) begin
            chk("sp_inc", inc_phi, 32'd7);
            chk("sp_wrap", {31'd0, wrap}, (i == 2 || i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Single point in single mode finishes after one dwell
        tick();
        go(2'd3, 9, 9, 3, 1);
        chk("s1_inc", inc_phi, 32'd9);
        tick();
        chk("s1_done0", {31'd0, done}, 32'd0);
        tick();
        chk("s1_done1", {31'd0, done}, 32'd1);
        chk("s1_wrap", {31'd0, wrap}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
